// File: rtl/alu_control_mdu.sv
// ALU control decoder with an iterative multiply/divide unit (MDU).
// Decodes aluop/funct into an ALU select and the jr, illegal and mfhi/mflo flags.
// Owns the HI/LO registers and raises a pipeline stall for HI/LO users while the MDU is active.
//
// Handshake: an MDU request (mult/multu/div/divu) or mthi/mtlo is accepted on a rising
// edge where valid_i=1 and stall=0. stall is high only while the MDU is in RUN or DONE
// and the EX instruction touches HI/LO. A stalled instruction holds its inputs until
// stall drops. No other instruction is ever stalled.
//
// DATA_W must be even and at least 4. 2**CNT_W must be greater than DATA_W.
module alu_control_mdu #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [2:0]        aluop,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic [3:0]        alu_sel,
    output logic              jumpreg,
    output logic              illegal,
    output logic              mf_hi,
    output logic              mf_lo,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done,
    output logic              stall
);

    // ALU select codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    // R-type funct codes
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   acc_q;      // partial product high half / partial remainder
    logic [DATA_W-1:0]   quo_q;      // multiplier shifting out / dividend shifting out, quotient in
    logic [DATA_W-1:0]   opb_q;      // multiplicand or divisor magnitude
    logic                is_div_q;
    logic                neg_res_q;  // negate product or quotient
    logic                neg_rem_q;  // negate remainder (dividend was negative)
    logic                dbz_q;      // divisor was zero
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic                is_rtype;
    logic                is_mdu_op;
    logic                is_hilo_op;
    logic                start;
    logic                mthi_we;
    logic                mtlo_we;
    logic                op_signed;
    logic                sign_a;
    logic                sign_b;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic                div_ge;
    logic [DATA_W-1:0]   step_acc;
    logic [DATA_W-1:0]   step_quo;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] prod_s;
    logic [DATA_W-1:0]   res_hi;
    logic [DATA_W-1:0]   res_lo;

    // Combinational ALU-control decode; every output has a default so nothing latches
    always_comb begin
        alu_sel = ALU_ADD;
        jumpreg = 1'b0;
        illegal = 1'b0;
        mf_hi   = 1'b0;
        mf_lo   = 1'b0;
        case (aluop)
            3'b000: alu_sel = ALU_ADD;
            3'b001: alu_sel = ALU_SUB;
            3'b011: alu_sel = ALU_AND;
            3'b100: alu_sel = ALU_OR;
            3'b101: alu_sel = ALU_XOR;
            3'b110: alu_sel = ALU_SLT;
            3'b111: alu_sel = ALU_SLTU;
            3'b010: begin
                case (funct)
                    F_ADD:   alu_sel = ALU_ADD;
                    F_SUB:   alu_sel = ALU_SUB;
                    F_AND:   alu_sel = ALU_AND;
                    F_OR:    alu_sel = ALU_OR;
                    F_NOR:   alu_sel = ALU_NOR;
                    F_SLT:   alu_sel = ALU_SLT;
                    F_SLTU:  alu_sel = ALU_SLTU;
                    F_XOR:   alu_sel = ALU_XOR;
                    F_SLL:   alu_sel = ALU_SLL;
                    F_SRL:   alu_sel = ALU_SRL;
                    F_SRA:   alu_sel = ALU_SRA;
                    F_JR:    jumpreg = 1'b1;
                    F_MFHI:  mf_hi   = 1'b1;
                    F_MFLO:  mf_lo   = 1'b1;
                    F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: alu_sel = ALU_ADD;
                    default: illegal = 1'b1;
                endcase
            end
            default: alu_sel = ALU_ADD;
        endcase
    end

    // Request classification, stall and operand magnitudes for the MDU
    always_comb begin
        is_rtype   = (aluop == 3'b010);
        is_mdu_op  = (funct[5:2] == 4'b0110);   // 0x18..0x1B
        is_hilo_op = (funct[5:2] == 4'b0100);   // 0x10..0x13
        stall      = valid_i & is_rtype & (is_mdu_op | is_hilo_op) & (state_q != S_IDLE);
        start      = valid_i & is_rtype & is_mdu_op & ~stall;
        mthi_we    = valid_i & is_rtype & (funct == F_MTHI) & ~stall;
        mtlo_we    = valid_i & is_rtype & (funct == F_MTLO) & ~stall;
        op_signed  = ~funct[0];                 // mult and div are the signed forms
        sign_a     = op_signed & rs_val[DATA_W-1];
        sign_b     = op_signed & rt_val[DATA_W-1];
        mag_a      = sign_a ? -rs_val : rs_val;
        mag_b      = sign_b ? -rt_val : rt_val;
    end

    // One radix-2 step: shift-add multiply or restoring divide on magnitudes
    always_comb begin
        mul_sum   = {1'b0, acc_q} + ({1'b0, opb_q} & {(DATA_W+1){quo_q[0]}});
        div_shift = {acc_q, quo_q[DATA_W-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        if (is_div_q) begin
            // When the divisor fits under the shifted remainder the true difference is below 2**DATA_W
            step_acc = div_ge ? (div_shift[DATA_W-1:0] - opb_q) : div_shift[DATA_W-1:0];
            step_quo = {quo_q[DATA_W-2:0], div_ge};
        end else begin
            step_acc = mul_sum[DATA_W:1];
            step_quo = {mul_sum[0], quo_q[DATA_W-1:1]};
        end
    end

    // Sign correction of the final step; a zero divisor leaves the dividend as remainder naturally
    always_comb begin
        prod   = {step_acc, step_quo};
        prod_s = neg_res_q ? -prod : prod;
        if (is_div_q) begin
            res_lo = dbz_q ? {DATA_W{1'b1}} : (neg_res_q ? -step_quo : step_quo);
            res_hi = neg_rem_q ? -step_acc : step_acc;
        end else begin
            res_hi = prod_s[2*DATA_W-1:DATA_W];
            res_lo = prod_s[DATA_W-1:0];
        end
    end

    // MDU state machine with HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            // mthi/mtlo can only be accepted in IDLE, so they never collide with a completion
            if (mthi_we) hi_q <= rs_val;
            if (mtlo_we) lo_q <= rs_val;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        cnt_q     <= CNT_W'(DATA_W);
                        is_div_q  <= funct[1];
                        neg_res_q <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        dbz_q     <= (rt_val == '0);
                        acc_q     <= '0;
                        quo_q     <= mag_a;
                        opb_q     <= mag_b;
                    end
                end
                S_RUN: begin
                    acc_q <= step_acc;
                    quo_q <= step_quo;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_control_mdu.sv
// Bench for alu_control_mdu: decode sweep, MDU scoreboard, stall handshake, mthi/mtlo, async reset.
module tb_alu_control_mdu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_i;
    logic [2:0]   aluop;
    logic [5:0]   funct;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic [3:0]   alu_sel;
    logic         jumpreg;
    logic         illegal;
    logic         mf_hi;
    logic         mf_lo;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall;

    logic [2*W-1:0] exp_q[$];
    int n_checks   = 0;
    int n_errors   = 0;
    int done_seen  = 0;
    int done_exp   = 0;

    alu_control_mdu #(.DATA_W(W), .CNT_W(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .aluop   (aluop),
        .funct   (funct),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .alu_sel (alu_sel),
        .jumpreg (jumpreg),
        .illegal (illegal),
        .mf_hi   (mf_hi),
        .mf_lo   (mf_lo),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // expected {alu_sel, jumpreg, illegal, mf_hi, mf_lo}
    function automatic logic [7:0] dec_model(input logic [2:0] a, input logic [5:0] f);
        logic [3:0] s;
        logic jr, ill, mh, ml;
        s = 4'd0; jr = 1'b0; ill = 1'b0; mh = 1'b0; ml = 1'b0;
        if (a != 3'b010) begin
            case (a)
                3'b000:  s = 4'd0;
                3'b001:  s = 4'd1;
                3'b011:  s = 4'd2;
                3'b100:  s = 4'd3;
                3'b101:  s = 4'd9;
                3'b110:  s = 4'd5;
                default: s = 4'd10;
            endcase
        end else begin
            case (f)
                6'h20: s = 4'd0;
                6'h22: s = 4'd1;
                6'h24: s = 4'd2;
                6'h25: s = 4'd3;
                6'h27: s = 4'd4;
                6'h2A: s = 4'd5;
                6'h2B: s = 4'd10;
                6'h26: s = 4'd9;
                6'h00: s = 4'd6;
                6'h02: s = 4'd7;
                6'h03: s = 4'd8;
                6'h08: jr = 1'b1;
                6'h10: mh = 1'b1;
                6'h12: ml = 1'b1;
                6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: s = 4'd0;
                default: ill = 1'b1;
            endcase
        end
        return {s, jr, ill, mh, ml};
    endfunction

    // reference {HI,LO} for an MDU op
    function automatic logic [63:0] ref_mdu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        longint sa, sb;
        int qs, ms;
        r = 64'd0;
        case (f)
            6'h18: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                r  = sa * sb;
            end
            6'h19: r = {32'd0, a} * {32'd0, b};
            6'h1A: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    qs = $signed(a) / $signed(b);
                    ms = $signed(a) % $signed(b);
                    r  = {ms, qs};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // scoreboard: compare HI/LO against the oldest expected result on each done pulse
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("sb_pending", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_hi", 64'(hi), 64'(e[2*W-1:W]));
                check("sb_lo", 64'(lo), 64'(e[W-1:0]));
            end
        end
    end

    task automatic drive_idle();
        valid_i = 1'b0;
        aluop   = 3'b000;
        funct   = 6'h00;
    endtask

    // issue one MDU op, push its result, and time it to the done pulse
    task automatic run_mdu(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] e);
        int cyc;
        @(negedge clk);
        valid_i = 1'b1; aluop = 3'b010; funct = f; rs_val = a; rt_val = b;
        #1;
        check("req_stall", 64'(stall), 64'd0);
        exp_q.push_back(e);
        done_exp++;
        @(posedge clk);            // request edge
        @(negedge clk);
        drive_idle();
        check("busy_run", 64'(busy), 64'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < W + 8) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("latency", 64'(cyc), 64'(W));
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("hold_hi", 64'(hi), 64'(e[2*W-1:W]));
        check("hold_lo", 64'(lo), 64'(e[W-1:0]));
    endtask

    initial begin
        int n;
        logic [5:0]   rf;
        logic [W-1:0] ra, rb;

        // reset
        rst_n = 1'b0;
        drive_idle();
        rs_val = '0;
        rt_val = '0;
        #12;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // decode sweep (valid_i low, so nothing reaches the MDU)
        for (int a = 0; a < 8; a++) begin
            for (int f = 0; f < 64; f++) begin
                aluop = 3'(a);
                funct = 6'(f);
                #1;
                check($sformatf("dec_a%0d_f%02h", a, f),
                      64'({alu_sel, jumpreg, illegal, mf_hi, mf_lo}), 64'(dec_model(3'(a), 6'(f))));
            end
        end
        aluop = 3'b010; funct = 6'h2B; #1; check("dec_sltu", 64'(alu_sel), 64'd10);
        funct = 6'h08; #1; check("dec_jr", 64'(jumpreg), 64'd1);
        funct = 6'h3F; #1; check("dec_ill", 64'({illegal, alu_sel}), 64'h10);
        aluop = 3'b101; #1; check("dec_xor", 64'(alu_sel), 64'd9);
        drive_idle();

        // directed MDU results
        run_mdu(6'h18, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        run_mdu(6'h19, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
        run_mdu(6'h1A, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_mdu(6'h1B, 32'd100, 32'd7, {32'd2, 32'd14});
        run_mdu(6'h1A, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
        run_mdu(6'h1A, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        run_mdu(6'h1B, 32'h8000_0005, 32'd0, {32'h8000_0005, 32'hFFFF_FFFF});

        // random MDU ops against the reference model
        for (int i = 0; i < 12; i++) begin
            rf = 6'h18 + 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            run_mdu(rf, ra, rb, ref_mdu(rf, ra, rb));
        end

        // mflo two cycles after mult stalls through DONE; an add during RUN flows
        @(negedge clk);
        valid_i = 1'b1; aluop = 3'b010; funct = 6'h18; rs_val = 32'hFFFF_FFFF; rt_val = 32'd2;
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        done_exp++;
        @(negedge clk);
        funct = 6'h20; rs_val = 32'd1; rt_val = 32'd1;
        #1;
        check("add_run_stall", 64'(stall), 64'd0);
        check("add_run_sel", 64'(alu_sel), 64'd0);
        check("add_run_busy", 64'(busy), 64'd1);
        @(negedge clk);
        funct = 6'h12;
        #1;
        check("mflo_flag", 64'(mf_lo), 64'd1);
        n = 0;
        while (stall === 1'b1 && n < W + 8) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("mflo_stall_cycles", 64'(n), 64'(W));
        check("mflo_release_state", 64'({busy, done}), 64'd0);
        check("mflo_lo", 64'(lo), 64'hFFFF_FFFE);
        drive_idle();

        // mthi/mtlo while idle
        @(negedge clk);
        valid_i = 1'b1; aluop = 3'b010; funct = 6'h11; rs_val = 32'h1234;
        @(negedge clk);
        check("mthi_idle", 64'(hi), 64'h1234);
        funct = 6'h13; rs_val = 32'h5678;
        @(negedge clk);
        check("mtlo_idle", 64'(lo), 64'h5678);
        check("mtlo_keeps_hi", 64'(hi), 64'h1234);
        drive_idle();

        // mthi during RUN waits for the divide to finish, then applies
        @(negedge clk);
        valid_i = 1'b1; aluop = 3'b010; funct = 6'h1B; rs_val = 32'd100; rt_val = 32'd7;
        exp_q.push_back({32'd2, 32'd14});
        done_exp++;
        @(negedge clk);
        funct = 6'h11; rs_val = 32'hABCD;
        #1;
        n = 0;
        while (stall === 1'b1 && n < W + 8) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("mthi_stall_cycles", 64'(n), 64'(W + 1));
        check("hi_before_mthi", 64'(hi), 64'd2);
        @(negedge clk);
        check("mthi_after", 64'(hi), 64'hABCD);
        check("lo_after_mthi", 64'(lo), 64'd14);
        drive_idle();

        // asynchronous reset at iteration 10 of a div discards it
        @(negedge clk);
        valid_i = 1'b1; aluop = 3'b010; funct = 6'h1A; rs_val = 32'hFFFF_FFF9; rt_val = 32'd2;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        repeat (9) @(negedge clk);
        check("busy_mid_div", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_mdu(6'h18, 32'd12345, 32'hFFFF_FFFD, ref_mdu(6'h18, 32'd12345, 32'hFFFF_FFFD));
        run_mdu(6'h19, 32'hDEAD_BEEF, 32'h1234_5678, ref_mdu(6'h19, 32'hDEAD_BEEF, 32'h1234_5678));

        // final report
        repeat (3) @(negedge clk);
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(done_seen), 64'(done_exp));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
